// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op encodings, FSM states and op-class helpers for alu_seq_param
package alu_seq_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SMUL = 3'b010;
  localparam logic [2:0] ALU_UMUL = 3'b011;
  localparam logic [2:0] ALU_UDIV = 3'b100;
  localparam logic [2:0] ALU_SDIV = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADQ,
    S_EXEC,
    S_FIX,
    S_OUT1,
    S_OUT2
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == ALU_UDIV) || (op == ALU_SDIV);
  endfunction

  function automatic logic is_mul(input logic [2:0] op);
    return (op == ALU_SMUL) || (op == ALU_UMUL);
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return op[2:1] != 2'b11;
  endfunction

endpackage

// File: rtl/alu_div_core.sv
// rtl/alu_div_core.sv - restoring divider on magnitudes, one bit per cycle, then a sign-fix cycle
module alu_div_core #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sgn,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  rem, quo, dvs;
  logic [CW-1:0] cnt;
  logic          run, fix, neg_q, neg_r;
  logic [W:0]    rem_sh;
  logic [W+1:0]  diff;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic s);
    return (s && x[W-1]) ? -x : x;
  endfunction

  // diff[W] can only be set together with a borrow, so testing both bits equals testing the borrow
  always_comb begin
    rem_sh = {rem, quo[W-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvs};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      cnt   <= '0;
      run   <= 1'b0;
      fix   <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      rem   <= '0;
      quo   <= mag(dividend, sgn);
      dvs   <= mag(divisor, sgn);
      neg_q <= sgn && (dividend[W-1] ^ divisor[W-1]);
      neg_r <= sgn && dividend[W-1];
      cnt   <= CW'(W - 1);
      run   <= 1'b1;
      fix   <= 1'b0;
    end else if (run) begin
      if (diff[W+1:W] == 2'b00) begin
        rem <= diff[W-1:0];
        quo <= {quo[W-2:0], 1'b1};
      end else begin
        rem <= rem_sh[W-1:0];
        quo <= {quo[W-2:0], 1'b0};
      end
      if (cnt == '0) begin
        run <= 1'b0;
        fix <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else if (fix) begin
      if (neg_q) quo <= -quo;
      if (neg_r) rem <= -rem;
      fix <= 1'b0;
    end
  end

  assign done      = fix;
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/alu_seq_param.sv
// rtl/alu_seq_param.sv - multi-cycle W-bit ALU: add/sub, Booth and shift-add multiply, restoring divide
module alu_seq_param
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] inbus,
  output logic [W-1:0] outbus,
  output logic         finish,
  output logic         busy,
  output logic         overflow,
  output logic         dbz,
  output logic         err
);

  localparam int CW = $clog2(W) + 1;

  state_t        state, state_nx;
  logic [2:0]    op_r;
  logic [W-1:0]  m, mq;
  logic [W:0]    acc;
  logic          q_1;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sum;
  logic          add_ov;
  logic [W:0]    booth_a, shadd_a;
  logic          div_start, div_done;
  logic [W-1:0]  div_quo, div_rem;

  alu_div_core #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .sgn       (op_r == ALU_SDIV),
    .dividend  (inbus),
    .divisor   (m),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // acc is one bit wider than W so the Booth partial sum and the unsigned carry never wrap
  always_comb begin
    sum     = (op_r == ALU_SUB) ? mq - m : mq + m;
    add_ov  = (op_r == ALU_SUB) ? ((mq[W-1] != m[W-1]) && (sum[W-1] != mq[W-1]))
                                : ((mq[W-1] == m[W-1]) && (sum[W-1] != mq[W-1]));
    booth_a = acc;
    case ({mq[0], q_1})
      2'b01:   booth_a = acc + {m[W-1], m};
      2'b10:   booth_a = acc - {m[W-1], m};
      default: booth_a = acc;
    endcase
    shadd_a = mq[0] ? acc + {1'b0, m} : acc;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOADQ;
      S_LOADQ: begin
        if (!is_legal(op_r))                state_nx = S_IDLE;
        else if (is_div(op_r) && m == '0)   state_nx = S_OUT1;
        else                                state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (!is_mul(op_r) && !is_div(op_r)) state_nx = S_OUT1;
        else if (cnt == '0)                 state_nx = is_div(op_r) ? S_FIX : S_OUT1;
      end
      S_FIX:   if (div_done) state_nx = S_OUT1;
      S_OUT1:  state_nx = (is_mul(op_r) || is_div(op_r)) ? S_OUT2 : S_IDLE;
      S_OUT2:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    finish    = (state == S_OUT1) || (state == S_OUT2);
    div_start = (state == S_LOADQ) && is_div(op_r) && (m != '0);
    outbus    = '0;
    if (state == S_OUT1) begin
      if (is_div(op_r)) outbus = dbz ? mq : div_rem;
      else              outbus = acc[W-1:0];
    end else if (state == S_OUT2) begin
      if (is_div(op_r)) outbus = dbz ? '1 : div_quo;
      else              outbus = mq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= '0;
      m        <= '0;
      mq       <= '0;
      acc      <= '0;
      q_1      <= 1'b0;
      cnt      <= '0;
      overflow <= 1'b0;
      dbz      <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_r     <= op;
          m        <= inbus;
          overflow <= 1'b0;
          dbz      <= 1'b0;
          err      <= 1'b0;
        end
        S_LOADQ: begin
          mq  <= inbus;
          acc <= '0;
          q_1 <= 1'b0;
          cnt <= CW'(W - 1);
          if (!is_legal(op_r))               err <= 1'b1;
          if (is_div(op_r) && m == '0)       dbz <= 1'b1;
          if (op_r == ALU_SDIV && m == '1 && inbus == {1'b1, {(W-1){1'b0}}})
            overflow <= 1'b1;
        end
        S_EXEC: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          if (op_r == ALU_SMUL) begin
            acc <= {booth_a[W], booth_a[W:1]};
            mq  <= {booth_a[0], mq[W-1:1]};
            q_1 <= mq[0];
          end else if (op_r == ALU_UMUL) begin
            acc <= {1'b0, shadd_a[W:1]};
            mq  <= {shadd_a[0], mq[W-1:1]};
          end else if (!is_div(op_r)) begin
            acc      <= {1'b0, sum};
            overflow <= add_ov;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// tb/tb_alu_seq_param.sv - table-driven bench for alu_seq_param (W=8) plus W=16 and reset/handshake sequences
module tb_alu_seq_param;
  import alu_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [2:0] op;
  logic [7:0] inbus, outbus;
  logic       finish, busy, overflow, dbz, err;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] in16, out16;
  logic        fin16, busy16, ov16, dbz16, err16;

  alu_seq_param #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .inbus(inbus), .outbus(outbus),
    .finish(finish), .busy(busy), .overflow(overflow), .dbz(dbz), .err(err)
  );

  alu_seq_param #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .inbus(in16), .outbus(out16),
    .finish(fin16), .busy(busy16), .overflow(ov16), .dbz(dbz16), .err(err16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] m, q;
    int         nb;
    logic [7:0] b1, b2;
    int         lat;
    logic       ov, dz, er;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string name, input logic [2:0] o, input logic [7:0] mm, qq,
                         input int nb, input logic [7:0] b1, b2, input int lat,
                         input logic ov, dz, er);
    vec_t v;
    v.name = name; v.op = o; v.m = mm; v.q = qq; v.nb = nb; v.b1 = b1; v.b2 = b2;
    v.lat = lat; v.ov = ov; v.dz = dz; v.er = er;
    vecs.push_back(v);
  endtask

  // Cycle k is observed at the falling edge inside Tk; T0 is the start cycle.
  task automatic run_vec(input vec_t v);
    logic [7:0] beats[2];
    int  nb, first, idle_bad;
    bit  done;
    @(negedge clk);
    start = 1'b1; op = v.op; inbus = v.m;
    @(negedge clk);
    start = 1'b0; inbus = v.q;
    check($sformatf("%s busy_t1", v.name), busy, 1);
    check($sformatf("%s flags_clear_t1", v.name), {overflow, dbz, err}, 0);
    nb = 0; first = -1; idle_bad = 0; done = 0;
    beats[0] = '0; beats[1] = '0;
    for (int k = 1; k <= 40 && !done; k++) begin
      if (k > 1) @(negedge clk);
      if (finish) begin
        if (nb < 2) beats[nb] = outbus;
        if (nb == 0) first = k;
        nb++;
      end else if (outbus != 8'h00) begin
        idle_bad++;
      end
      if (!busy) done = 1;
    end
    check($sformatf("%s completed", v.name), done, 1);
    check($sformatf("%s nbeats", v.name), nb, v.nb);
    check($sformatf("%s first_beat_cycle", v.name), first, v.lat);
    check($sformatf("%s outbus_zero_when_idle", v.name), idle_bad, 0);
    if (v.nb >= 1) check($sformatf("%s beat1", v.name), beats[0], v.b1);
    if (v.nb == 2) check($sformatf("%s beat2", v.name), beats[1], v.b2);
    check($sformatf("%s overflow", v.name), overflow, v.ov);
    check($sformatf("%s dbz", v.name), dbz, v.dz);
    check($sformatf("%s err", v.name), err, v.er);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] b16[2];
    int          f16, n16;
    vec_t        v;

    add_vec("add_basic",  ALU_ADD,  8'h39, 8'h43, 1, 8'h7C, 8'h00,  3, 0, 0, 0);
    add_vec("add_ovf",    ALU_ADD,  8'h7F, 8'h7E, 1, 8'hFD, 8'h00,  3, 1, 0, 0);
    add_vec("sub_ovf",    ALU_SUB,  8'h01, 8'h80, 1, 8'h7F, 8'h00,  3, 1, 0, 0);
    add_vec("sub_neg",    ALU_SUB,  8'h05, 8'h03, 1, 8'hFE, 8'h00,  3, 0, 0, 0);
    add_vec("smul_a",     ALU_SMUL, 8'hA3, 8'h8D, 2, 8'h29, 8'hC7, 10, 0, 0, 0);
    add_vec("smul_b",     ALU_SMUL, 8'h59, 8'h9F, 2, 8'hDE, 8'h47, 10, 0, 0, 0);
    add_vec("umul_max",   ALU_UMUL, 8'hFF, 8'hFF, 2, 8'hFE, 8'h01, 10, 0, 0, 0);
    add_vec("umul_small", ALU_UMUL, 8'h0D, 8'h0B, 2, 8'h00, 8'h8F, 10, 0, 0, 0);
    add_vec("udiv",       ALU_UDIV, 8'h0D, 8'hD9, 2, 8'h09, 8'h10, 11, 0, 0, 0);
    add_vec("sdiv_neg_q", ALU_SDIV, 8'h07, 8'h9C, 2, 8'hFE, 8'hF2, 11, 0, 0, 0);
    add_vec("sdiv_corner",ALU_SDIV, 8'hFF, 8'h80, 2, 8'h00, 8'h80, 11, 1, 0, 0);
    add_vec("sdiv_neg_m", ALU_SDIV, 8'hFD, 8'h07, 2, 8'h01, 8'hFE, 11, 0, 0, 0);
    add_vec("udiv_zero",  ALU_UDIV, 8'h00, 8'h55, 2, 8'h55, 8'hFF,  2, 0, 1, 0);
    add_vec("illegal110", 3'b110,   8'h12, 8'h34, 0, 8'h00, 8'h00, -1, 0, 0, 1);
    add_vec("add_after",  ALU_ADD,  8'h01, 8'h02, 1, 8'h03, 8'h00,  3, 0, 0, 0);
    add_vec("illegal111", 3'b111,   8'h00, 8'h00, 0, 8'h00, 8'h00, -1, 0, 0, 1);
    add_vec("sdiv_zero",  ALU_SDIV, 8'h00, 8'h80, 2, 8'h80, 8'hFF,  2, 0, 1, 0);

    rst = 1'b1; start = 1'b0; op = '0; inbus = '0;
    start16 = 1'b0; op16 = '0; in16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset outputs", {outbus, finish, busy, overflow, dbz, err}, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // start during the last beat is dropped; start one cycle later is taken
    @(negedge clk); start = 1'b1; op = ALU_ADD; inbus = 8'h10;
    @(negedge clk); start = 1'b0; inbus = 8'h20;
    @(negedge clk);
    @(negedge clk);
    check("hs beat_t3", {finish, outbus}, {1'b1, 8'h30});
    start = 1'b1; inbus = 8'h05;
    @(negedge clk);
    check("hs start_on_last_beat_ignored", busy, 0);
    @(negedge clk);
    check("hs start_after_accepted", busy, 1);
    start = 1'b0; inbus = 8'h06;
    @(negedge clk);
    @(negedge clk);
    check("hs second_result", {finish, outbus}, {1'b1, 8'h0B});
    @(negedge clk);

    // synchronous reset in the middle of a divide
    @(negedge clk); start = 1'b1; op = ALU_SDIV; inbus = 8'hFF;
    @(negedge clk); start = 1'b0; inbus = 8'h80;
    @(negedge clk);
    @(negedge clk);
    check("rst pre overflow", {busy, overflow}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid_op outputs", {outbus, finish, busy, overflow, dbz, err}, 0);
    rst = 1'b0;
    v = vecs[0];
    v.name = "add_after_rst";
    run_vec(v);

    // W=16 signed multiply of the most negative value by itself
    @(negedge clk); start16 = 1'b1; op16 = ALU_SMUL; in16 = 16'h8000;
    @(negedge clk); start16 = 1'b0; in16 = 16'h8000;
    n16 = 0; f16 = -1; b16[0] = '0; b16[1] = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      if (fin16) begin
        if (n16 < 2) b16[n16] = out16;
        if (n16 == 0) f16 = k;
        n16++;
      end
      if (!busy16) break;
    end
    check("w16 nbeats", n16, 2);
    check("w16 first_beat_cycle", f16, 18);
    check("w16 beat_hi", b16[0], 16'h4000);
    check("w16 beat_lo", b16[1], 16'h0000);
    check("w16 flags", {ov16, dbz16, err16}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
